// File: rtl/usart_rx_fifo_param.sv
// Parametrised USART receive FIFO: DEPTH frames with frame/parity/overrun tags,
// occupancy level, full flag, fill-threshold interrupt and synchronous flush.
module usart_rx_fifo_param #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_shift_register,
  input  logic                  i_shift_register_valid,
  input  logic                  i_frame_error,
  input  logic                  i_parity_error,
  input  logic                  i_mcu_read,
  input  logic                  i_flush,
  input  logic [AW:0]           i_threshold,
  output logic [DATA_WIDTH-1:0] o_udr,
  output logic                  o_udr_valid,
  output logic                  o_frame_error_flag,
  output logic                  o_parity_error_flag,
  output logic                  o_data_overrun_flag,
  output logic [AW:0]           o_level,
  output logic                  o_full,
  output logic                  o_threshold_irq
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      fe_q, fe_d;
  logic [DEPTH-1:0]      pe_q, pe_d;
  logic [DEPTH-1:0]      ovr_q, ovr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  irq_q, irq_d;

  logic full, empty, do_push, do_pop, overrun;

  always_comb begin
    full    = (level_q == LVL_FULL);
    empty   = (level_q == '0);
    do_pop  = i_mcu_read && !empty && !i_flush;
    // A full FIFO still accepts a frame when a pop frees a slot in the same cycle.
    do_push = i_shift_register_valid && (!full || do_pop) && !i_flush;
    overrun = i_shift_register_valid && full && !do_pop && !i_flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    fe_d     = fe_q;
    pe_d     = pe_q;
    ovr_d    = ovr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovr_d    = '0;
    end else begin
      if (do_push) begin
        fe_d[wr_ptr_q]  = i_frame_error;
        pe_d[wr_ptr_q]  = i_parity_error;
        ovr_d[wr_ptr_q] = 1'b0;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      // Dropped frame is reported on the newest stored entry.
      if (overrun) begin
        ovr_d[wr_ptr_q - PTR_ONE] = 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
    irq_d = (i_threshold != '0) && (level_d >= i_threshold);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      fe_q     <= '0;
      pe_q     <= '0;
      ovr_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      fe_q     <= fe_d;
      pe_q     <= pe_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
    end
  end

  // Frame storage is never reset; empty entries are masked at the outputs.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_shift_register;
    end
  end

  always_comb begin
    o_udr               = empty ? '0   : mem_q[rd_ptr_q];
    o_frame_error_flag  = empty ? 1'b0 : fe_q[rd_ptr_q];
    o_parity_error_flag = empty ? 1'b0 : pe_q[rd_ptr_q];
    o_data_overrun_flag = empty ? 1'b0 : ovr_q[rd_ptr_q];
    o_udr_valid         = !empty;
    o_level             = level_q;
    o_full              = full;
    o_threshold_irq     = irq_q;
  end

endmodule

// File: tb/tb_usart_rx_fifo_param.sv
// Scoreboard bench for usart_rx_fifo_param: a queue-based reference model predicts
// the visible state after every clock; a negedge monitor compares it with the DUT.
module tb_usart_rx_fifo_param;

  localparam int DW    = 9;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] sr = '0;
  logic          sr_vld = 1'b0;
  logic          fe = 1'b0;
  logic          pe = 1'b0;
  logic          rd = 1'b0;
  logic          fl = 1'b0;
  logic [AW:0]   thr = '0;

  logic [DW-1:0] udr;
  logic          udr_vld, fe_flag, pe_flag, ovr_flag, full, irq;
  logic [AW:0]   level;

  usart_rx_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_shift_register       (sr),
    .i_shift_register_valid (sr_vld),
    .i_frame_error          (fe),
    .i_parity_error         (pe),
    .i_mcu_read             (rd),
    .i_flush                (fl),
    .i_threshold            (thr),
    .o_udr                  (udr),
    .o_udr_valid            (udr_vld),
    .o_frame_error_flag     (fe_flag),
    .o_parity_error_flag    (pe_flag),
    .o_data_overrun_flag    (ovr_flag),
    .o_level                (level),
    .o_full                 (full),
    .o_threshold_irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          fe;
    logic          pe;
    logic          ovr;
  } ent_t;

  typedef struct packed {
    logic [DW-1:0] udr;
    logic          vld;
    logic          fe;
    logic          pe;
    logic          ovr;
    logic [AW:0]   level;
    logic          full;
    logic          irq;
  } snap_t;

  ent_t  mq[$];
  snap_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
  endtask

  // Reference model: a FIFO of frames, advanced once per clock from the applied inputs.
  task automatic model(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic f, input logic p, input logic rdi, input logic fli);
    ent_t  e;
    snap_t s;
    bit    popped;
    if (r || fli) begin
      mq.delete();
    end else begin
      popped = rdi && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      if (v) begin
        if (mq.size() < DEPTH) begin
          e = '{d: d, fe: f, pe: p, ovr: 1'b0};
          mq.push_back(e);
        end else begin
          mq[mq.size()-1].ovr = 1'b1;
        end
      end
    end
    s = '0;
    if (mq.size() > 0) begin
      s.udr = mq[0].d;
      s.vld = 1'b1;
      s.fe  = mq[0].fe;
      s.pe  = mq[0].pe;
      s.ovr = mq[0].ovr;
    end
    s.level = (AW+1)'(mq.size());
    s.full  = (mq.size() == DEPTH);
    s.irq   = r ? 1'b0 : ((thr != 0) && (mq.size() >= int'(thr)));
    exp_q.push_back(s);
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic f, input logic p, input logic rdi, input logic fli);
    rst = r; sr_vld = v; sr = d; fe = f; pe = p; rd = rdi; fl = fli;
    @(posedge clk);
    model(r, v, d, f, p, rdi, fli);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic f);
    step(1'b0, 1'b1, d, f, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: outputs are continuously presented, so one expected snapshot per clock.
  always @(negedge clk) begin
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      chk("udr",       32'(udr),      32'(s.udr));
      chk("udr_valid", 32'(udr_vld),  32'(s.vld));
      chk("fe_flag",   32'(fe_flag),  32'(s.fe));
      chk("pe_flag",   32'(pe_flag),  32'(s.pe));
      chk("ovr_flag",  32'(ovr_flag), 32'(s.ovr));
      chk("level",     32'(level),    32'(s.level));
      chk("full",      32'(full),     32'(s.full));
      chk("irq",       32'(irq),      32'(s.irq));
    end
  end

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic ordering and tags
    push(9'h155, 1'b1);
    push(9'h0AA, 1'b0);
    idle();
    pop();
    pop();
    idle();

    // Overrun: fifth frame dropped, newest entry tagged
    for (int i = 1; i <= 5; i++) push(DW'(i), 1'b0);
    for (int i = 0; i < 6; i++) pop();

    // Simultaneous push+pop on full, pointer wrap
    for (int i = 1; i <= 4; i++) push(DW'(i), 1'b0);
    step(1'b0, 1'b1, 9'h0F0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) pop();

    // Threshold interrupt
    thr = 3;
    for (int i = 0; i < 3; i++) push(DW'(9'h010 + i), 1'b0);
    idle();
    pop();
    idle();
    thr = 0;
    for (int i = 0; i < 3; i++) push(DW'(9'h020 + i), 1'b0);
    thr = 5;
    idle();
    thr = 0;
    for (int i = 0; i < 4; i++) pop();

    // Flush wins over simultaneous push and pop
    for (int i = 0; i < 3; i++) push(DW'(9'h040 + i), 1'b1);
    step(1'b0, 1'b1, 9'h1FF, 1'b1, 1'b1, 1'b1, 1'b1);
    push(9'h033, 1'b0);
    pop();

    // Reset mid-stream while full, then pop on empty
    for (int i = 0; i < 5; i++) push(DW'(9'h060 + i), 1'b0);
    thr = 2;
    step(1'b1, 1'b1, 9'h077, 1'b0, 1'b0, 1'b1, 1'b0);
    pop();
    pop();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) thr = (AW+1)'($urandom_range(0, DEPTH + 1));
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1,
           DW'($urandom),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 39) == 0);
    end

    idle();
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usart_rx_fifo_param.md
Name: usart_rx_fifo_param

Overview:
Parametrised receive buffer for the USART receiver, placed between the receive shift register and the MCU data register interface. Stores DEPTH frames of DATA_WIDTH bits, each with per-frame frame-error, parity-error and data-overrun tags. Adds the following over the fixed two-stage receive buffer:
- occupancy level
- full flag
- programmable fill-threshold interrupt
- synchronous flush

Parameters:
DATA_WIDTH, 9, frame width incl. optional 9th bit (>=5)
DEPTH, 4, number of entries; power of two, >=2
AW, log2(DEPTH), pointer width (derived, not overridden)

Ports:
i_clk  input  1  system clock
i_rst  input  1  system reset; synchronous, active-high
i_shift_register  input  DATA_WIDTH  received frame from shift register
i_shift_register_valid  input  1  one-cycle push strobe; frame and error inputs valid this cycle
i_frame_error  input  1  frame error of the pushed frame
i_parity_error  input  1  parity error of the pushed frame
i_mcu_read  input  1  one-cycle pop strobe (MCU read of data register)
i_flush  input  1  one-cycle synchronous clear of all entries
i_threshold  input  AW+1  irq threshold, 0 = irq disabled
o_udr  output  DATA_WIDTH  head frame
o_udr_valid  output  1  FIFO not empty
o_frame_error_flag  output  1  head frame error tag
o_parity_error_flag  output  1  head parity error tag
o_data_overrun_flag  output  1  head overrun tag
o_level  output  AW+1  entries stored, 0..DEPTH
o_full  output  1  o_level == DEPTH
o_threshold_irq  output  1  registered; i_threshold!=0 and o_level>=i_threshold

Behaviour:
- Single clock domain: i_clk. Reset is synchronous and active-high (i_rst), sampled on the rising edge of i_clk.
- Reset state:
  - pointers, level and all tag bits = 0
  - all outputs = 0
  - storage contents don't-care (masked)
- Storage: DEPTH entries of {ovr, pe, fe, data}. Write pointer and read pointer are AW bits, wrap modulo DEPTH. Level counter is AW+1 bits.
- Push (i_shift_register_valid=1, not full, or full with simultaneous pop):
  - write {0, i_parity_error, i_frame_error, i_shift_register} at wr_ptr
  - wr_ptr+1
- Push while full and no pop (overrun):
  - incoming frame dropped; contents unchanged
  - ovr bit set on the newest entry (wr_ptr-1 mod DEPTH)
  - level stays DEPTH
- Pop (i_mcu_read=1 and level>0): rd_ptr+1. Pop on empty is ignored; level never underflows.
- Simultaneous push+pop:
  - non-empty: both performed, level unchanged
  - empty: push only
  - full: both performed, no overrun
- Flush (i_flush=1):
  - pointers, level and ovr tags cleared next cycle
  - priority over push and pop in the same cycle; those are discarded
- Priority order: i_rst > i_flush > push/pop.
- Latency:
  - frame pushed in cycle N appears on o_udr with o_udr_valid=1 at N+1 if FIFO was empty
  - after pop in cycle N, next head visible at N+1
  - o_level and o_full update at N+1
  - o_threshold_irq is registered from the next-state level, so it is also valid at N+1
- Head outputs: o_udr and the three tag flags show the head entry when level>0, and are forced to 0 when empty.
- An ovr tag set on the current head entry (level==1 and full only when DEPTH==1, excluded) is visible immediately next cycle.
- i_threshold > DEPTH: irq never asserts. i_threshold may change at any time; irq re-evaluates next cycle.

Test Plan:
- DEPTH=4: reset, push 0x155 with fe=1, then 0x0AA -> o_udr=0x155, o_frame_error_flag=1, o_level=2. After one i_mcu_read: o_udr=0x0AA, flags 0, o_level=1.
- Push 5 frames 0x001..0x005 with no reads -> o_full=1, o_level=4, 0x005 dropped. Popping gives 0x001, 0x002, 0x003, then 0x004 with o_data_overrun_flag=1, then o_udr_valid=0.
- Full FIFO, push 0x0F0 and pop in same cycle -> no overrun, o_level stays 4. Four further pops return 0x002, 0x003, 0x004, 0x0F0; pointers wrap correctly.
- i_threshold=3: push 3 frames -> o_threshold_irq=1 the cycle after the 3rd push; one pop -> irq=0 next cycle. i_threshold=0 -> irq stays 0 at any level.
- With 3 entries, assert i_flush together with a push and a pop -> next cycle o_level=0, o_udr_valid=0, o_udr=0. Next push 0x033 is read back as 0x033.
- Assert i_rst mid-stream with FIFO full -> next cycle all outputs 0. Pop on empty is ignored, o_level stays 0.
